// File: rtl/led_breath_ctrl.sv
// LED driver: off / on / blink / triangle-ramp PWM breathing, selected by a GPIO control word.
// State | meaning:  RISE | duty ramping up toward MAX;  FALL | duty ramping down toward 0
module led_breath_ctrl #(
  parameter int PWM_W    = 8,
  parameter int STEP_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ctrl_mode,
  input  logic [3:0]       ctrl_speed,
  output logic             led,
  output logic [PWM_W-1:0] duty,
  output logic             cycle_done
);

  localparam int PRE_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_W-1:0] MAX = '1;

  typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATHE} mode_e;
  typedef enum logic {ST_RISE, ST_FALL} breath_e;

  mode_e            mode_q, mode_p;
  logic [3:0]       speed_q;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]       sub_cnt_q, sub_cnt_d;
  logic [PWM_W-1:0] pwm_cnt_q;
  logic [PWM_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;
  breath_e          state_q;
  logic [PWM_W-1:0] duty_q;
  logic             led_q, cycle_done_q;

  logic mode_chg, pre_term, sub_term, step_tick;

  assign mode_chg = (mode_q != mode_p);

  // A lowered speed leaves sub_cnt above the new terminal; >= lets it wrap at the next prescaler end.
  always_comb begin
    pre_term  = (pre_cnt_q == PRE_TERM);
    sub_term  = (sub_cnt_q >= speed_q);
    pre_cnt_d = pre_term ? '0 : pre_cnt_q + 1'b1;
    sub_cnt_d = sub_cnt_q;
    if (pre_term) sub_cnt_d = sub_term ? '0 : sub_cnt_q + 1'b1;
    step_tick = pre_term && sub_term && !mode_chg;
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (mode_q == MODE_BLINK && step_tick) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      if (blink_cnt_q == MAX) blink_ph_d = ~blink_ph_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_OFF;
      mode_p       <= MODE_OFF;
      speed_q      <= '0;
      pre_cnt_q    <= '0;
      sub_cnt_q    <= '0;
      pwm_cnt_q    <= '0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b1;
      state_q      <= ST_RISE;
      duty_q       <= '0;
      led_q        <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      mode_q       <= mode_e'(ctrl_mode);
      mode_p       <= mode_q;
      speed_q      <= ctrl_speed;
      cycle_done_q <= 1'b0;
      if (mode_chg) begin
        pre_cnt_q   <= '0;
        sub_cnt_q   <= '0;
        pwm_cnt_q   <= '0;
        blink_cnt_q <= '0;
        blink_ph_q  <= 1'b1;
        state_q     <= ST_RISE;
        duty_q      <= '0;
        led_q       <= 1'b0;
      end else begin
        pre_cnt_q   <= pre_cnt_d;
        sub_cnt_q   <= sub_cnt_d;
        pwm_cnt_q   <= pwm_cnt_q + 1'b1;
        blink_cnt_q <= blink_cnt_d;
        blink_ph_q  <= blink_ph_d;
        case (mode_q)
          MODE_OFF: begin
            duty_q <= '0;
            led_q  <= 1'b0;
          end
          MODE_ON: begin
            duty_q <= MAX;
            led_q  <= 1'b1;
          end
          MODE_BLINK: begin
            duty_q <= blink_ph_d ? MAX : '0;
            led_q  <= blink_ph_d;
          end
          default: begin
            led_q <= (pwm_cnt_q < duty_q);
            if (step_tick) begin
              if (state_q == ST_RISE) begin
                if (duty_q == MAX) begin
                  state_q <= ST_FALL;
                  duty_q  <= MAX - 1'b1;
                end else begin
                  duty_q <= duty_q + 1'b1;
                end
              end else begin
                if (duty_q == '0) begin
                  state_q      <= ST_RISE;
                  duty_q       <= {{(PWM_W-1){1'b0}}, 1'b1};
                  cycle_done_q <= 1'b1;
                end else begin
                  duty_q <= duty_q - 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign led        = led_q;
  assign duty       = duty_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_breath_ctrl.sv
// Scoreboard bench for led_breath_ctrl: a closed-form model pushes expected outputs per edge,
// a negedge monitor pops and compares them against the DUT.
module tb_led_breath_ctrl;
  localparam int PWM_W    = 4;
  localparam int STEP_DIV = 4;
  localparam int MAXV     = (1 << PWM_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       ctrl_mode = 2'd0;
  logic [3:0]       ctrl_speed = 4'd0;
  logic             led;
  logic [PWM_W-1:0] duty;
  logic             cycle_done;

  always #5 clk = ~clk;

  led_breath_ctrl #(.PWM_W(PWM_W), .STEP_DIV(STEP_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_mode(ctrl_mode), .ctrl_speed(ctrl_speed),
    .led(led), .duty(duty), .cycle_done(cycle_done)
  );

  typedef struct packed {
    logic             led;
    logic [PWM_W-1:0] duty;
    logic             cd;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  // model: input pipeline, clocks since clear, ticks since clear, prescaler terminals since last tick
  int m_mode_q, m_mode_p, m_speed_q, m_e, m_n, m_k, m_duty;
  bit m_led, m_cd;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic int tri_duty(input int n);
    int r;
    if (n == 0) return 0;
    r = (n - 1) % (2 * MAXV) + 1;
    return (r <= MAXV) ? r : 2 * MAXV - r;
  endfunction

  task automatic model_reset();
    m_mode_q = 0; m_mode_p = 0; m_speed_q = 0;
    m_e = 0; m_n = 0; m_k = 0;
    m_duty = 0; m_led = 0; m_cd = 0;
  endtask

  task automatic model_edge();
    bit tick;
    int old_duty, old_pwm;
    bit ph;
    old_duty = m_duty;
    old_pwm  = m_e % (MAXV + 1);
    if (m_mode_q != m_mode_p) begin
      m_e = 0; m_n = 0; m_k = 0;
      m_duty = 0; m_led = 0; m_cd = 0;
    end else begin
      tick = 0;
      if (m_e % STEP_DIV == STEP_DIV - 1) begin
        if (m_k >= m_speed_q) begin
          tick = 1;
          m_k = 0;
        end else begin
          m_k++;
        end
      end
      m_e++;
      if (tick) m_n++;
      m_cd = 0;
      case (m_mode_q)
        0: begin m_duty = 0;    m_led = 0; end
        1: begin m_duty = MAXV; m_led = 1; end
        2: begin
          ph = ((m_n / (MAXV + 1)) % 2) == 0;
          m_led  = ph;
          m_duty = ph ? MAXV : 0;
        end
        default: begin
          m_led  = (old_pwm < old_duty);
          m_duty = tri_duty(m_n);
          m_cd   = tick && (m_n > 2 * MAXV) && ((m_n - 1) % (2 * MAXV) == 0);
        end
      endcase
    end
    m_mode_p  = m_mode_q;
    m_mode_q  = int'(ctrl_mode);
    m_speed_q = int'(ctrl_speed);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    if (rst_n) begin
      model_edge();
      e.led  = m_led;
      e.duty = PWM_W'(m_duty);
      e.cd   = m_cd;
      sb_q.push_back(e);
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_led", int'(led), 0);
      chk("rst_duty", int'(duty), 0);
      chk("rst_cycle_done", int'(cycle_done), 0);
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("led", int'(led), int'(e.led));
      chk("duty", int'(duty), int'(e.duty));
      chk("cycle_done", int'(cycle_done), int'(e.cd));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    model_reset();
    rst_n = 0; ctrl_mode = 2'd3; ctrl_speed = 4'd0;
    run(4);
    rst_n = 1;

    run(300);                            // breathe, speed 0
    ctrl_mode = 2'd2; run(300);          // blink
    ctrl_mode = 2'd3; ctrl_speed = 4'd3; run(1000);

    found = 0;                           // drop speed while sub_cnt sits at 2
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (m_k == 2) found = 1;
    end
    if (!found) begin failures++; $display("FAIL wait_sub_cnt2 timeout t=%0t", $time); end
    ctrl_speed = 4'd0; run(40);

    found = 0;                           // switch to ON mid-ramp at duty 9
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (m_duty == 9 && m_mode_q == 3 && m_mode_p == 3) found = 1;
    end
    if (!found) begin failures++; $display("FAIL wait_duty9 timeout t=%0t", $time); end
    ctrl_mode = 2'd1; run(20);
    ctrl_mode = 2'd3; run(100);

    found = 0;                           // async reset in FALL at duty 6
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (m_duty == 6 && m_n > MAXV && ((m_n - 1) % (2 * MAXV)) >= MAXV) found = 1;
    end
    if (!found) begin failures++; $display("FAIL wait_fall6 timeout t=%0t", $time); end
    @(negedge clk); #1;
    chk("pre_reset_duty", int'(duty), 6);
    rst_n = 0;
    model_reset();
    sb_q.delete();
    #1;
    chk("async_rst_led", int'(led), 0);
    chk("async_rst_duty", int'(duty), 0);
    chk("async_rst_cycle_done", int'(cycle_done), 0);
    run(3);
    rst_n = 1;
    run(200);

    for (int s = 0; s < 40; s++) begin   // random mode/speed segments
      ctrl_mode  = 2'($urandom_range(0, 3));
      ctrl_speed = 4'($urandom_range(0, 3));
      run(int'($urandom_range(1, 150)));
    end
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_breath_ctrl.md
# led_breath_ctrl

Fabric-side LED driver sitting between the processing-system GPIO output and the board LED pin. It samples a small control word from the GPIO and produces one of four LED behaviours: off, on, blink or PWM "breathing". Breathing uses a triangle duty ramp. All logic runs on the single fabric clock that also clocks the GPIO block.

## Interface
- PWM_W, 8: width of the PWM counter and of the duty value; MAX = 2^PWM_W-1.
- STEP_DIV, 100000: clocks per prescaler period; must be >= 2.
- clk  input  1  fabric clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low (one clock, asynchronous active-low reset; fixed).
- ctrl_mode  input  2  0 = OFF, 1 = ON, 2 = BLINK, 3 = BREATHE; level from GPIO.
- ctrl_speed  input  4  slows the step rate; step period = STEP_DIV*(ctrl_speed+1) clocks.
- led  output  1  LED drive, registered.
- duty  output  PWM_W  current duty value, registered, for observation.
- cycle_done  output  1  one-clock pulse at the end of each full breath cycle.

## Operation
- Input stage: ctrl_mode and ctrl_speed are registered into mode_q and speed_q. mode_p holds the previous mode_q. A mode change is the condition mode_q != mode_p.
- Prescaler:
  - pre_cnt counts 0..STEP_DIV-1.
  - At its terminal value, sub_cnt advances over 0..speed_q.
  - step_tick fires when both counters are at terminal. Both counters then wrap to 0.
  - If speed_q is lowered below the current sub_cnt, the comparison is sub_cnt >= speed_q, so the next prescaler terminal produces a tick and wraps sub_cnt.
- PWM counter: pwm_cnt increments every clock, modulo 2^PWM_W, free-running.
- Mode change (any transition, including into the same mode after reset):
  - pre_cnt, sub_cnt, pwm_cnt, blink_cnt and duty are cleared.
  - blink_ph is set to 1. Breath state goes to RISE.
  - No step_tick is produced in that cycle.
- OFF: led = 0, duty = 0.
- ON: led = 1, duty = MAX.
- BLINK:
  - blink_cnt (PWM_W bits) increments on each step_tick. blink_ph toggles when blink_cnt wraps from MAX to 0.
  - led = blink_ph. duty = MAX when blink_ph = 1, else 0.
- BREATHE: state machine with states RISE and FALL.
  - RISE on step_tick: if duty == MAX, go to FALL and set duty = MAX-1; else duty + 1.
  - FALL on step_tick: if duty == 0, go to RISE, set duty = 1 and pulse cycle_done; else duty - 1.
  - led = (pwm_cnt < duty) using unsigned PWM_W-bit compare. duty 0 gives a constant-off LED. duty MAX gives MAX/2^PWM_W on-time.
  - One breath cycle = 2*MAX step_ticks.
- cycle_done is only asserted in BREATHE. It is never asserted on a mode change.
- Unused modes do not exist: all 4 codes are defined.

## Timing
- Reset (rst_n low, any time including mid-ramp):
  - led = 0, duty = 0, cycle_done = 0.
  - All counters = 0, blink_ph = 1, breath state RISE.
  - mode_q, mode_p and speed_q = 0 (OFF).
- Release: the first active edge after rst_n rises is a normal cycle. There is no synchronous recovery delay beyond the input register.
- Latency: a ctrl_mode change present at edge N is in mode_q after N. Counters clear at N+1. led and duty reflect the new mode after edge N+2.
- ctrl_speed change: takes effect from the cycle after it is registered. There is no counter clear.
- led, duty and cycle_done are all outputs of flops. duty and cycle_done change on the same edge as the state update. led follows the registered pwm/duty compare one clock later.
- Simultaneous mode change and step_tick: the mode change wins and the tick is dropped.
- Wrap-around: pwm_cnt and blink_cnt wrap silently. duty never exceeds MAX or goes below 0.

## Test plan
Parameters for all scenarios: PWM_W=4, STEP_DIV=4, ctrl_speed=0 unless stated (MAX=15, step_tick every 4 clocks).
- Reset: hold rst_n low with ctrl_mode=3, then release -> led=0, duty=0, cycle_done=0 during reset; breathing starts with duty stepping 0→1 at the first tick.
- BREATHE cycle: ctrl_mode=3 -> duty ramps 0..15 then 14..0. cycle_done pulses for 1 clock every 30 ticks = 120 clocks. At duty=8, led is high 8 of every 16 clocks.
- BLINK: ctrl_mode=2 -> led=1 for 16 ticks (64 clocks), then 0 for 64 clocks, repeating. duty alternates 15/0.
- Speed: ctrl_speed=3 in BREATHE -> tick every 16 clocks and cycle_done period 480 clocks. Then change ctrl_speed 3→0 while sub_cnt=2 -> the next tick occurs at the next prescaler terminal.
- Mode change mid-ramp: switch 3→1 at duty=9 -> led=1 and duty=15 two clocks after the input change, with no cycle_done. Switch back to 3 -> duty restarts at 0 in RISE.
- Async reset mid-FALL: pulse rst_n low at duty=6 -> led and duty go to 0 immediately without waiting for clk; the ramp restarts from RISE.
